// File: rtl/bus_sram_responder.sv
// Chip-selected SRAM responder for the core data bus.
// Accepts one transaction at a time and grants after WAIT_STATES cycles.
module bus_sram_responder #(
  parameter int CE_BIT      = 1,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  bus_ce_i,
  input  logic        bus_req_i,
  input  logic        bus_we_i,
  input  logic [1:0]  bus_hb_i,
  input  logic [31:0] bus_addr_i,
  input  logic [31:0] bus_wdata_i,
  output logic [31:0] bus_rdata_o,
  output logic        bus_gnt_o,
  output logic        busy_o
);

  localparam int          LP_DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0]  LP_WAIT  = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  state_t                r_state, w_nextState;
  logic [3:0]            r_cnt;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [1:0]            r_lane;
  logic [1:0]            r_hb;
  logic                  r_we;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic [31:0]           r_mem [0:LP_DEPTH-1];

  logic                  w_sel;
  logic [DEPTH_LOG2-1:0] w_busIdx;
  logic [DEPTH_LOG2-1:0] w_readIdx;
  logic                  w_readWe;
  logic                  w_enterAck;
  logic [3:0]            w_mask;
  logic [31:0]           w_alignedData;
  logic                  w_unused;

  assign w_sel    = bus_ce_i[CE_BIT] & bus_req_i;
  assign w_busIdx = bus_addr_i[DEPTH_LOG2+1:2];
  assign w_unused = ^{bus_ce_i, bus_addr_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: if (w_sel) w_nextState = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
      S_WAIT: begin
        if (!w_sel)           w_nextState = S_IDLE;
        else if (r_cnt == 4'd1) w_nextState = S_ACK;
      end
      S_ACK:   w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    bus_gnt_o = (r_state == S_ACK);
    busy_o    = (r_state != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_lane  <= '0;
      r_hb    <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
    end else if (r_state == S_IDLE && w_sel) begin
      r_cnt   <= LP_WAIT;
      r_idx   <= w_busIdx;
      r_lane  <= bus_addr_i[1:0];
      r_hb    <= bus_hb_i;
      r_we    <= bus_we_i;
      r_wdata <= bus_wdata_i;
    end else if (r_state == S_WAIT && w_sel && r_cnt != 4'd1) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // With zero wait states ACK is entered straight from IDLE, so the
  // read must use the live bus fields rather than the not-yet-latched ones.
  assign w_readWe   = (r_state == S_IDLE) ? bus_we_i : r_we;
  assign w_readIdx  = (r_state == S_IDLE) ? w_busIdx : r_idx;
  assign w_enterAck = (w_nextState == S_ACK) && (r_state != S_ACK);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                       r_rdata <= '0;
    else if (w_enterAck && !w_readWe) r_rdata <= r_mem[w_readIdx];
  end

  assign bus_rdata_o = r_rdata;

  always_comb begin
    w_mask        = 4'b1111;
    w_alignedData = r_wdata;
    case (r_hb)
      2'b00: begin
        w_mask        = 4'b0001 << r_lane;
        w_alignedData = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_mask        = r_lane[1] ? 4'b1100 : 4'b0011;
        w_alignedData = {2{r_wdata[15:0]}};
      end
      default: begin
        w_mask        = 4'b1111;
        w_alignedData = r_wdata;
      end
    endcase
  end

  // Memory is deliberately not reset; a reset during ACK forces IDLE first.
  always_ff @(posedge clk_i) begin
    if (r_state == S_ACK && r_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_mask[b]) r_mem[r_idx][8*b +: 8] <= w_alignedData[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_bus_sram_responder.sv
// Self-checking bench: two responders share one bus (CE_BIT=1/2 waits, CE_BIT=3/0 waits)
// and are checked against a per-word reference memory.
module tb_bus_sram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ce;
  logic        req;
  logic        we;
  logic [1:0]  hb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdataA, rdataB;
  logic        gntA, gntB, busyA, busyB;

  int errors = 0;
  int checks = 0;

  logic [31:0] modelA [int];
  logic [31:0] modelB [int];

  always #5 clk = ~clk;

  bus_sram_responder #(.CE_BIT(1), .DEPTH_LOG2(10), .WAIT_STATES(2)) dutA (
    .clk_i(clk), .rst_i(rst), .bus_ce_i(ce), .bus_req_i(req), .bus_we_i(we),
    .bus_hb_i(hb), .bus_addr_i(addr), .bus_wdata_i(wdata),
    .bus_rdata_o(rdataA), .bus_gnt_o(gntA), .busy_o(busyA));

  bus_sram_responder #(.CE_BIT(3), .DEPTH_LOG2(10), .WAIT_STATES(0)) dutB (
    .clk_i(clk), .rst_i(rst), .bus_ce_i(ce), .bus_req_i(req), .bus_we_i(we),
    .bus_hb_i(hb), .bus_addr_i(addr), .bus_wdata_i(wdata),
    .bus_rdata_o(rdataB), .bus_gnt_o(gntB), .busy_o(busyB));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int wordIdx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  // Reference write rule: merge new bytes into the old word by size and lane.
  function automatic logic [31:0] mergeWrite(input logic [31:0] old, input logic [1:0] size,
                                             input logic [31:0] a, input logic [31:0] d);
    logic [31:0] w;
    w = old;
    if (size == 2'b00)      w[8*a[1:0] +: 8]  = d[7:0];
    else if (size == 2'b01) w[16*a[1] +: 16]  = d[15:0];
    else                    w = d;
    return w;
  endfunction

  task automatic applyStimulus(input logic [7:0] c, input logic r, input logic w,
                               input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    ce = c; req = r; we = w; hb = s; addr = a; wdata = d;
  endtask

  // One complete transaction, started at a negedge (cycle 0).
  task automatic txn(input bit useB, input logic w, input logic [1:0] s,
                     input logic [31:0] a, input logic [31:0] d, input string tag);
    int gntCycle;
    int expCycle;
    logic [31:0] old;
    logic [31:0] expRd;
    gntCycle = 0;
    expCycle = useB ? 1 : 3;
    @(negedge clk);
    applyStimulus(useB ? 8'h08 : 8'h02, 1'b1, w, s, a, d);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (useB ? gntB : gntA) begin
        gntCycle = c;
        break;
      end
    end
    check({tag, "_gntCycle"}, gntCycle, expCycle);
    if (!w && gntCycle != 0) begin
      expRd = useB ? modelB[wordIdx(a)] : modelA[wordIdx(a)];
      check({tag, "_rdata"}, useB ? rdataB : rdataA, expRd);
    end
    if (w && gntCycle != 0) begin
      if (useB) begin
        old = modelB.exists(wordIdx(a)) ? modelB[wordIdx(a)] : 32'h0;
        modelB[wordIdx(a)] = mergeWrite(old, s, a, d);
      end else begin
        old = modelA.exists(wordIdx(a)) ? modelA[wordIdx(a)] : 32'h0;
        modelA[wordIdx(a)] = mergeWrite(old, s, a, d);
      end
    end
    req = 1'b0;
    @(negedge clk);
    check({tag, "_gntOnePulse"}, {31'b0, useB ? gntB : gntA}, 32'h0);
  endtask

  initial begin
    logic [7:0]  gntTrace;
    logic [31:0] rAddr;
    logic [1:0]  rSize;
    int          k;

    rst = 1'b1;
    applyStimulus(8'h00, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    check("reset_gntA", {31'b0, gntA}, 32'h0);
    check("reset_busyA", {31'b0, busyA}, 32'h0);
    check("reset_rdataA", rdataA, 32'h0);
    check("reset_busyB", {31'b0, busyB}, 32'h0);
    rst = 1'b0;

    // Word write then read with two wait states.
    txn(1'b0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, "t1_write");
    txn(1'b0, 1'b0, 2'b10, 32'h10, 32'h0, "t1_read");
    check("t1_value", rdataA, 32'hDEADBEEF);

    // Byte and halfword lane masking.
    txn(1'b0, 1'b1, 2'b00, 32'h13, 32'h000000AB, "t2_byte");
    txn(1'b0, 1'b1, 2'b01, 32'h10, 32'h00001234, "t2_half");
    txn(1'b0, 1'b0, 2'b10, 32'h10, 32'h0, "t2_read");
    check("t2_value", rdataA, 32'hABAD1234);

    // Foreign chip select is ignored by both responders.
    @(negedge clk);
    applyStimulus(8'h04, 1'b1, 1'b1, 2'b10, 32'h10, 32'h55555555);
    k = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (gntA || busyA || gntB || busyB) k++;
    end
    check("t3a_noActivity", k, 0);
    req = 1'b0;

    // Request dropped during WAIT aborts without writing.
    @(negedge clk);
    applyStimulus(8'h02, 1'b1, 1'b1, 2'b10, 32'h10, 32'h55555555);
    @(negedge clk);
    check("t3b_busyInWait", {31'b0, busyA}, 32'h1);
    req = 1'b0;
    k = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (gntA || busyA) k++;
    end
    check("t3b_aborted", k, 0);
    txn(1'b0, 1'b0, 2'b10, 32'h10, 32'h0, "t3b_read");
    check("t3b_value", rdataA, 32'hABAD1234);

    // Zero wait states, request held for four back-to-back writes.
    @(negedge clk);
    applyStimulus(8'h08, 1'b1, 1'b1, 2'b10, 32'h0, 32'hA0000000);
    modelB[0] = 32'hA0000000;
    gntTrace = '0;
    k = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      gntTrace[c-1] = gntB;
      if (gntB) begin
        k++;
        if (k < 4) begin
          addr  = 32'(4 * k);
          wdata = 32'hA0000000 + 32'(k);
          modelB[k] = wdata;
        end else begin
          req = 1'b0;
        end
      end
    end
    check("t4_gntPattern", {24'b0, gntTrace}, 32'h55);
    for (int i = 0; i < 4; i++) begin
      txn(1'b1, 1'b0, 2'b10, 32'(4 * i), 32'h0, $sformatf("t4_read%0d", i));
      check($sformatf("t4_value%0d", i), rdataB, 32'hA0000000 + 32'(i));
    end

    // Asynchronous reset during WAIT drops the write.
    txn(1'b0, 1'b1, 2'b10, 32'h20, 32'h11111111, "t5_pre");
    txn(1'b0, 1'b0, 2'b10, 32'h20, 32'h0, "t5_preRead");
    @(negedge clk);
    applyStimulus(8'h02, 1'b1, 1'b1, 2'b10, 32'h20, 32'h99999999);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_gnt", {31'b0, gntA}, 32'h0);
    check("t5_busy", {31'b0, busyA}, 32'h0);
    check("t5_rdata", rdataA, 32'h0);
    @(negedge clk);
    req = 1'b0;
    rst = 1'b0;
    txn(1'b0, 1'b0, 2'b10, 32'h20, 32'h0, "t5_read");
    check("t5_value", rdataA, 32'h11111111);

    // Upper address bits alias onto the same word.
    txn(1'b0, 1'b1, 2'b10, 32'h1000_0008, 32'hCAFEF00D, "t6_write");
    txn(1'b0, 1'b0, 2'b10, 32'h0000_0008, 32'h0, "t6_read");
    check("t6_value", rdataA, 32'hCAFEF00D);

    // Random mixed-size traffic over eight words.
    for (int i = 0; i < 8; i++)
      txn(1'b0, 1'b1, 2'b10, 32'h40 + 32'(4 * i), $urandom, $sformatf("rnd_init%0d", i));
    for (int i = 0; i < 30; i++) begin
      rAddr = 32'h40 + 32'($urandom_range(0, 31)) + (32'($urandom_range(0, 3)) << 12);
      rSize = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0)
        txn(1'b0, 1'b1, rSize, rAddr, $urandom, $sformatf("rnd_w%0d", i));
      else
        txn(1'b0, 1'b0, rSize, rAddr, 32'h0, $sformatf("rnd_r%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_sram_responder.md
Name: bus_sram_responder

Overview:
- Slave-side endpoint of the core's req/gnt/chip-select data bus.
- Owns one chip-select bit and holds a word-organised SRAM.
- Answers bus requests after a programmable number of wait states with a single-cycle grant; this grant is what ends the core's bus stall.
- Performs byte, halfword and word writes with lane masking, and returns the full aligned word on reads.

Parameters:
- CE_BIT, 1, index of bus_ce_i bit that selects this responder
- DEPTH_LOG2, 10, log2 of memory depth in 32-bit words (default 1024 words / 4 KiB)
- WAIT_STATES, 2, cycles inserted between request acceptance and grant (0..15)

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  reset, asynchronous, active-high
- bus_ce_i  input  8  one-hot chip select from the core LSU
- bus_req_i  input  1  bus request
- bus_we_i  input  1  1 = write, 0 = read
- bus_hb_i  input  2  size: 00 byte, 01 halfword, 10/11 word
- bus_addr_i  input  32  byte address
- bus_wdata_i  input  32  write data, low-aligned (byte in [7:0], halfword in [15:0])
- bus_rdata_o  output  32  read data, full aligned word
- bus_gnt_o  output  1  grant/completion, high exactly one cycle per transaction
- busy_o  output  1  high while a transaction is in progress (WAIT or ACK)

Behaviour:
Selection
- sel = bus_ce_i[CE_BIT] & bus_req_i.
- Other ce bits are ignored.

Word index and aliasing
- Word index = bus_addr_i[DEPTH_LOG2+1:2].
- Upper address bits are ignored, so addresses alias modulo 4*2^DEPTH_LOG2.

FSM states: IDLE, WAIT, ACK
- IDLE, sel=1: latch addr, we, hb, wdata; cnt <= WAIT_STATES; go to ACK if WAIT_STATES==0, else go to WAIT.
- WAIT: if sel=0, abort to IDLE (no write, rdata unchanged). Else if cnt==1, go to ACK; else cnt--.
- ACK: bus_gnt_o=1; always return to IDLE next cycle.
- On entry to ACK with latched we=0, bus_rdata_o <= mem[latched index].

Timing
- If req first appears in cycle 0, WAIT occupies cycles 1..W and gnt is high in cycle W+1 only.
- bus_gnt_o and busy_o are pure decodes of the state register (glitch-free): gnt = (state==ACK); busy = (state!=IDLE).

Writes
- Commit at the rising edge ending the ACK cycle, using latched values only.
- Bus changes during WAIT/ACK are ignored, except deassertion of sel, which aborts.

Lane rules
- Byte: lane = addr[1:0]; mem byte[lane] <= wdata[7:0]; other bytes are preserved.
- Halfword: lane = addr[1]; mem half[lane] <= wdata[15:0]; addr[0] is ignored (no misalignment fault).
- Word: full 32-bit write; addr[1:0] are ignored.

Read data
- Always the whole word; byte/halfword extraction and sign handling belong to the core LSU.
- bus_rdata_o holds its last value until the next completed read.

Back-to-back transactions
- After ACK the FSM passes through IDLE for one cycle.
- A request still present in that IDLE cycle is treated as a new transaction.
- Minimum throughput is one transaction per WAIT_STATES+2 cycles.

Hazards
- A read following a write to the same word returns the written data; the write has committed before the read's ACK entry.

Reset
- rst_i asserted at any time: state=IDLE, cnt=0, bus_gnt_o=0, busy_o=0, bus_rdata_o=0.
- Any in-flight transaction is dropped with no memory write.
- Memory contents are not reset.

Test Plan:
1. Word write + read, WAIT_STATES=2, CE_BIT=1
   - Stimulus: ce=8'h02, req=1, we=1, hb=10, addr=0x10, wdata=0xDEADBEEF from cycle 0.
   - Required: gnt high in cycle 3 only. Then a read of 0x10 returns 0xDEADBEEF with gnt high in cycle 3 of that transaction.
2. Byte and halfword lane masking
   - Stimulus: after test 1, byte write addr=0x13 wdata=0x000000AB, then halfword write addr=0x10 wdata=0x00001234.
   - Required: word 0x10 reads 0xABAD1234.
3. Deselect / abort
   - Stimulus (a): ce=8'h04 with req=1. Required: no gnt, busy_o=0.
   - Stimulus (b): correct ce, req dropped in cycle 1. Required: FSM back to IDLE, no gnt, word unchanged.
4. Zero wait states and back-to-back
   - Stimulus: WAIT_STATES=0, req held high for 4 consecutive word writes to 0x0, 0x4, 0x8, 0xC.
   - Required: gnt pulses in cycles 1, 3, 5, 7. All four words are written correctly.
5. Reset mid-operation
   - Stimulus: assert rst_i asynchronously during WAIT of a write to 0x20 (prior value 0x11111111).
   - Required: gnt, busy_o and rdata go to 0 immediately; 0x20 still reads 0x11111111 after reset release.
6. Address aliasing
   - Stimulus: DEPTH_LOG2=10, write 0xCAFEF00D to 0x1000_0008.
   - Required: a read of 0x0000_0008 returns 0xCAFEF00D.
